regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the two-read/two-write register file used by the pipeline decode and writeback stages.
- Two combinational read ports (A, B) and two synchronous write ports (E from execute, M from memory). The number of registers and the data width are configurable.
- Adds a per-register pending-write scoreboard so the hazard unit can stall on outstanding writes.
- Optional read-during-write bypass.

Parameters:
- DATA_WID, 32, width of each register and data port.
- ADDR_WID, 4, width of the register-index ports.
- NUM_REGS, 15, number of physical registers (indices 0..NUM_REGS-1); must be at most 2**ADDR_WID-1.
- RNONE, 2**ADDR_WID-1, index meaning "no register". Reads of it return 0; writes or reserves to it are ignored.
- PEND_WID, 2, width of each per-register pending counter.

Ports:
- CLK  in  1  clock, rising-edge active.
- RST_N  in  1  asynchronous, active-low reset.
- srcA  in  ADDR_WID  read index, port A.
- srcB  in  ADDR_WID  read index, port B.
- valA  out  DATA_WID  read data, port A (combinational).
- valB  out  DATA_WID  read data, port B (combinational).
- destE  in  ADDR_WID  write index, port E; RNONE means no write.
- valE  in  DATA_WID  write data, port E.
- destM  in  ADDR_WID  write index, port M; RNONE means no write.
- valM  in  DATA_WID  write data, port M.
- resv_en  in  1  reserve request (decode issues an instruction that will write resv_dest).
- resv_dest  in  ADDR_WID  register being reserved.
- busyA  out  1  srcA has a nonzero pending count (combinational).
- busyB  out  1  srcB has a nonzero pending count (combinational).
- resv_ovf  out  1  registered sticky flag: a reserve was dropped because its counter was saturated.

Behaviour:
- Reset (RST_N low, asynchronous):
  - all registers clear to 0;
  - all pending counters clear to 0;
  - resv_ovf clears to 0.
  - Reset asserted mid-cycle takes effect immediately. Any write or reserve sampled while RST_N is low is discarded.
- Read:
  - valX = reg[srcX] when srcX < NUM_REGS, else 0. This includes RNONE and unused indices.
  - No clock latency.
- Write (rising CLK edge):
  - reg[destE] <= valE when destE < NUM_REGS.
  - reg[destM] <= valM when destM < NUM_REGS.
  - destE == destM (valid index): M wins, because the later pipeline stage is the newer result.
  - Out-of-range or RNONE indices: no state change.
- Scoreboard: pend[r] is an unsigned PEND_WID-bit counter. Per rising edge, for each r:
  - inc = 1 if resv_en and resv_dest == r and pend[r] != max; else 0.
  - dec = (destE == r) + (destM == r), range 0..2.
  - pend[r] <= max(pend[r] + inc - dec, 0). Saturates at 0 and never wraps below.
  - Reserve and release of the same register in the same cycle apply net.
- resv_ovf:
  - Sets on an edge where resv_en is high, resv_dest < NUM_REGS, and pend[resv_dest] == 2**PEND_WID-1 before the update.
  - Stays set until reset.
- Busy: busyX = (srcX < NUM_REGS) and (pend[srcX] != 0).
  - Without bypass, busy reflects the pre-edge count.
  - With bypass, busy is suppressed when the in-flight write on destE or destM targets srcX and would bring the count to 0 (see below).
- No X propagation: every output is driven to a defined value for any input combination once out of reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - valX is forwarded from the current-cycle write port when srcX matches destM (priority) or destE, and the index is valid.
  - busyX is computed from the post-decrement count of the current cycle.
  - Decode sees the writeback value with zero cycles of delay.
- Undefined:
  - Reads return array contents only; a same-cycle write becomes visible after the edge.
  - busyX uses the registered count.
  - No forwarding logic is synthesised.

Test Plan:
- Reset clear: after release, write reg 3 = 0x12345678 via E, then pulse RST_N low asynchronously between edges -> valA reads 0 immediately with srcA=3; busyA stays 0.
- Dual write collision: destE=destM=5, valE=0xAAAA, valM=0x5555, one edge -> srcA=5 reads 0x5555.
- RNONE handling: destE=15, valE=0xFFFF_FFFF, resv_en with resv_dest=15 -> no register changes; valA with srcA=15 is 0; busyA stays 0; resv_ovf stays 0.
- Scoreboard count: reserve reg 7 three times -> busyA=1 for srcA=7. A fourth reserve sets resv_ovf=1 and the count stays at 3. Three writes to destE=7 -> busyA returns to 0 on the edge after the third write.
- Simultaneous reserve and release: pend[2]=1, same edge resv_dest=2 and destM=2 -> pend stays 1 and busyA=1. Next edge destE=2 and destM=2 with pend=1 -> pend saturates at 0.
- Bypass: destE=4, valE=0x0BAD_F00D, srcB=4, sampled before the edge -> valB=0x0BAD_F00D with REGFILE_BYPASS_EN defined, and the old value (0) without it.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two combinational read ports, two synchronous write
// ports (E from execute, M from memory; M wins on a same-index collision) and
// a per-register pending-write counter that the hazard unit uses to stall.
// Optional read-during-write bypass is enabled by defining REGFILE_BYPASS_EN;
// without it, reads show array contents and busy uses the registered count.
module regfile_scoreboard #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 4,
    parameter int NUM_REGS = 15,
    parameter int RNONE    = 2**ADDR_WID - 1,
    parameter int PEND_WID = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM,
    input  logic                resv_en,
    input  logic [ADDR_WID-1:0] resv_dest,
    output logic                busyA,
    output logic                busyB,
    output logic                resv_ovf
);

    // Counter arithmetic is done two bits wider so inc/dec never overflow.
    localparam int CW = PEND_WID + 2;
    localparam logic [PEND_WID-1:0] PEND_MAX = '1;

    logic [DATA_WID-1:0] regFile [NUM_REGS];
    logic [PEND_WID-1:0] pend    [NUM_REGS];
    logic [PEND_WID-1:0] pendNext[NUM_REGS];
    logic [CW-1:0]       decCnt  [NUM_REGS];
    logic [NUM_REGS-1:0] busyVec;
    logic                ovfHit;

    // Subtract with a floor of zero: the count never wraps below empty.
    function automatic logic [CW-1:0] satSub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        satSub = (a >= b) ? (a - b) : '0;
    endfunction

    // A physical register index never aliases the "no register" index.
    function automatic logic isReg(input int r);
        isReg = (r != RNONE);
    endfunction

    // Next pending count per register, busy source, and overflow detection.
    always_comb begin
        ovfHit  = 1'b0;
        busyVec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic          hitResv;
            logic [CW-1:0] incCnt;
            hitResv   = isReg(r) && resv_en && (resv_dest == ADDR_WID'(r));
            incCnt    = CW'(hitResv && (pend[r] != PEND_MAX));
            decCnt[r] = CW'(isReg(r) && (destE == ADDR_WID'(r)))
                      + CW'(isReg(r) && (destM == ADDR_WID'(r)));
            pendNext[r] = PEND_WID'(satSub(CW'(pend[r]) + incCnt, decCnt[r]));
            if (hitResv && (pend[r] == PEND_MAX)) begin
                ovfHit = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            busyVec[r] = (satSub(CW'(pend[r]), decCnt[r]) != '0);
`else
            busyVec[r] = (pend[r] != '0);
`endif
        end
    end

    // Register array writes; M is applied after E so the newer result wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (isReg(r) && (destE == ADDR_WID'(r))) begin
                    regFile[r] <= valE;
                end
                if (isReg(r) && (destM == ADDR_WID'(r))) begin
                    regFile[r] <= valM;
                end
            end
        end
    end

    // Pending counters and the sticky reserve-overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
            resv_ovf <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= pendNext[r];
            end
            if (ovfHit) begin
                resv_ovf <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [ADDR_WID:0] numRegsW;
    logic              validE;
    logic              validM;
    assign numRegsW = (ADDR_WID+1)'(NUM_REGS);
    assign validE   = ({1'b0, destE} < numRegsW) && (destE != ADDR_WID'(RNONE));
    assign validM   = ({1'b0, destM} < numRegsW) && (destM != ADDR_WID'(RNONE));
`endif

    // Combinational read ports and busy flags; unused indices read as zero.
    always_comb begin
        valA  = '0;
        valB  = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (isReg(r) && (srcA == ADDR_WID'(r))) begin
                valA  = regFile[r];
                busyA = busyVec[r];
            end
            if (isReg(r) && (srcB == ADDR_WID'(r))) begin
                valB  = regFile[r];
                busyB = busyVec[r];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (validE && (destE == srcA)) valA = valE;
        if (validM && (destM == srcA)) valA = valM;
        if (validE && (destE == srcB)) valB = valE;
        if (validM && (destM == srcB)) valB = valM;
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard: expectations are queued when a
// step is driven and popped when the corresponding output is sampled.
module tb_regfile_scoreboard;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  srcA, srcB, destE, destM, resv_dest;
    logic [31:0] valA, valB, valE, valM;
    logic        resv_en, busyA, busyB, resv_ovf;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];

    regfile_scoreboard dut (
        .CLK(CLK), .RST_N(RST_N),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .destE(destE), .valE(valE), .destM(destM), .valM(valM),
        .resv_en(resv_en), .resv_dest(resv_dest),
        .busyA(busyA), .busyB(busyB), .resv_ovf(resv_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic expectVal(input string tag, input logic [31:0] e);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkVal(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("FAIL underflow: observed %h with no queued expectation", obs);
            return;
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic idle();
        destE = 4'd15; valE = '0; destM = 4'd15; valM = '0;
        resv_en = 1'b0; resv_dest = 4'd15;
    endtask

    // Clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; srcA = 4'd3; srcB = 4'd15;
        idle();
        #2;
        expectVal("rst_valA", 32'h0);
        expectVal("rst_busyA", 32'h0);
        expectVal("rst_ovf", 32'h0);
        checkVal(valA); checkVal(32'(busyA)); checkVal(32'(resv_ovf));
        step();
        RST_N = 1'b1;

        // Write reg 3 then pulse reset between edges.
        destE = 4'd3; valE = 32'h1234_5678;
        step(); idle(); #1;
        expectVal("wr3", 32'h1234_5678);
        checkVal(valA);
        #2 RST_N = 1'b0; #1;
        expectVal("async_rst_valA", 32'h0);
        expectVal("async_rst_busyA", 32'h0);
        checkVal(valA); checkVal(32'(busyA));
        #1 RST_N = 1'b1;

        // Dual write collision: M wins.
        step();
        destE = 4'd5; valE = 32'h0000_AAAA; destM = 4'd5; valM = 32'h0000_5555;
        step(); idle(); srcA = 4'd5; #1;
        expectVal("collision_M_wins", 32'h0000_5555);
        checkVal(valA);

        // RNONE writes/reserves change nothing.
        destE = 4'd15; valE = 32'hFFFF_FFFF; resv_en = 1'b1; resv_dest = 4'd15;
        step(); idle(); srcA = 4'd15; srcB = 4'd5; #1;
        expectVal("rnone_valA", 32'h0);
        expectVal("rnone_busyA", 32'h0);
        expectVal("rnone_ovf", 32'h0);
        expectVal("rnone_reg5_kept", 32'h0000_5555);
        checkVal(valA); checkVal(32'(busyA)); checkVal(32'(resv_ovf)); checkVal(valB);

        // Reserve reg 7 three times, then a fourth that overflows.
        srcA = 4'd7;
        for (int i = 0; i < 3; i++) begin
            resv_en = 1'b1; resv_dest = 4'd7;
            step();
        end
        idle(); #1;
        expectVal("resv3_busyA", 32'h1);
        expectVal("resv3_ovf", 32'h0);
        checkVal(32'(busyA)); checkVal(32'(resv_ovf));
        resv_en = 1'b1; resv_dest = 4'd7;
        step(); idle(); #1;
        expectVal("resv4_ovf", 32'h1);
        expectVal("resv4_busy_kept", 32'h1);
        checkVal(32'(resv_ovf)); checkVal(32'(busyA));
        for (int i = 0; i < 3; i++) begin
            destE = 4'd7; valE = 32'h70 + 32'(i);
            step(); idle(); #1;
            expectVal($sformatf("release%0d_busyA", i), (i < 2) ? 32'h1 : 32'h0);
            checkVal(32'(busyA));
        end
        expectVal("release_val7", 32'h72);
        checkVal(valA);

        // Simultaneous reserve and release on reg 2, then double release.
        srcA = 4'd2;
        resv_en = 1'b1; resv_dest = 4'd2;
        step(); idle();
        resv_en = 1'b1; resv_dest = 4'd2; destM = 4'd2; valM = 32'h22;
        step(); idle(); #1;
        expectVal("net_busyA", 32'h1);
        expectVal("net_val2", 32'h22);
        checkVal(32'(busyA)); checkVal(valA);
        destE = 4'd2; valE = 32'h23; destM = 4'd2; valM = 32'h24;
        step(); idle(); #1;
        expectVal("floor_busyA", 32'h0);
        expectVal("floor_val2", 32'h24);
        checkVal(32'(busyA)); checkVal(valA);

        // Bypass: reserve reg 4, then observe during the releasing write.
        srcB = 4'd4;
        resv_en = 1'b1; resv_dest = 4'd4;
        step(); idle(); #1;
        expectVal("byp_pre_busyB", 32'h1);
        checkVal(32'(busyB));
        destE = 4'd4; valE = 32'h0BAD_F00D; #1;
`ifdef REGFILE_BYPASS_EN
        expectVal("byp_valB", 32'h0BAD_F00D);
        expectVal("byp_busyB", 32'h0);
`else
        expectVal("byp_valB", 32'h0);
        expectVal("byp_busyB", 32'h1);
`endif
        checkVal(valB); checkVal(32'(busyB));
        step(); idle(); #1;
        expectVal("byp_post_valB", 32'h0BAD_F00D);
        expectVal("byp_post_busyB", 32'h0);
        checkVal(valB); checkVal(32'(busyB));
        srcA = 4'd4;
        destE = 4'd4; valE = 32'h1; destM = 4'd4; valM = 32'h2; #1;
`ifdef REGFILE_BYPASS_EN
        expectVal("byp_M_priority", 32'h2);
`else
        expectVal("byp_M_priority", 32'h0BAD_F00D);
`endif
        checkVal(valA);
        step(); idle();

        // Mid-cycle reset clears the sticky overflow flag.
        #2 RST_N = 1'b0; #1;
        expectVal("rst_clears_ovf", 32'h0);
        checkVal(32'(resv_ovf));
        RST_N = 1'b1;

        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: observed %0d queued expectations, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
